remote_cmd_sched: RTL

- Command scheduler in front of RemoteComm.
- Buffers 16-bit commands from the host-side logic in a small FIFO and launches them one at a time through RemoteComm's snd_cmd/cmd_snt handshake.
- Waits for the robot's 1-byte response on resp_rx_data and retires the command on ACK.
- Retries on NAK or timeout, and flags an error after the retry limit.

---
 rtl/remote_cmd_sched_pkg.sv | 23 ++
 rtl/remote_cmd_sched_if.sv | 52 +++++
 rtl/remote_cmd_sched_fifo.sv | 94 +++++++++
 rtl/remote_cmd_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/remote_cmd_sched_pkg.sv
// Shared types and constants for the remote command scheduler.
// The state encoding and the ACK byte value live here so that the
// scheduler and any monitoring logic agree on them.
package remote_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_SNT,
    WAIT_RESP,
    RETIRE
  } state_t;

  // Response byte that acknowledges a command; anything else is a NAK
  localparam logic [7:0] RESP_ACK = 8'hA5;

  // Width of an occupancy counter able to hold 0..depth
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/remote_cmd_sched_if.sv
// Bus bundle between the scheduler, the host-side logic and RemoteComm.
// master = the scheduler, slave = host logic / RemoteComm.
// Optional macro REMOTE_SCHED_FLUSH_EN adds the flush request line.
interface remote_cmd_sched_if #(
  parameter int DEPTH = 4
);
  import remote_sched_pkg::*;

  localparam int CW = occ_width(DEPTH);

  // host side
  logic          push;
  logic [15:0]   push_cmd;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
`ifdef REMOTE_SCHED_FLUSH_EN
  logic          flush;
`endif
  // RemoteComm side
  logic          snd_cmd;
  logic [15:0]   cmd;
  logic          cmd_snt;
  logic          resp_rx_rdy;
  logic [7:0]    resp_rx_data;
  logic          resp_clr_rx_rdy;
  // status
  logic          busy;
  logic          done;
  logic          err;
  logic          err_clr;
  logic [7:0]    resp_last;

  modport master (
`ifdef REMOTE_SCHED_FLUSH_EN
    input  flush,
`endif
    input  push, push_cmd, cmd_snt, resp_rx_rdy, resp_rx_data, err_clr,
    output full, empty, count, snd_cmd, cmd, resp_clr_rx_rdy,
    output busy, done, err, resp_last
  );

  modport slave (
`ifdef REMOTE_SCHED_FLUSH_EN
    output flush,
`endif
    output push, push_cmd, cmd_snt, resp_rx_rdy, resp_rx_data, err_clr,
    input  full, empty, count, snd_cmd, cmd, resp_clr_rx_rdy,
    input  busy, done, err, resp_last
  );

endinterface

// File: rtl/remote_cmd_sched_fifo.sv
// cmd_fifo: small circular command queue with a combinational head.
// The head must be visible in the same cycle the scheduler decides to
// launch, so the read is taken straight from the storage array.
// Optional macro REMOTE_SCHED_FLUSH_EN adds flush/keep_head inputs.
module cmd_fifo
  import remote_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
`ifdef REMOTE_SCHED_FLUSH_EN
  input  logic                       flush,
  input  logic                       keep_head,
`endif
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [occ_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  // A push into a full queue is dropped even if a pop frees a slot now
`ifdef REMOTE_SCHED_FLUSH_EN
  assign wr_en = push && !full && !flush;
`else
  assign wr_en = push && !full;
`endif
  assign rd_en = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (wr_en) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_en) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
`ifdef REMOTE_SCHED_FLUSH_EN
    if (flush) begin
      if (keep_head && !empty) begin
        // keep only the in-flight head entry
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = rd_ptr_reg + 1'b1;
        count_next  = CW'(1);
      end else begin
        wr_ptr_next = rd_ptr_next;
        count_next  = '0;
      end
    end
`endif
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage array; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched: queues host commands and launches them one at a
// time through RemoteComm, retiring on ACK and retrying on NAK/timeout.
// Optional macro REMOTE_SCHED_FLUSH_EN adds a flush input that drops
// every queued command except the one currently in flight.
module remote_cmd_sched
  import remote_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 50_000_000,
  parameter int MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  remote_cmd_sched_if.master bus
);

  localparam int CW = occ_width(DEPTH);
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        state_reg, state_next;
  logic [15:0]   cmd_reg, cmd_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          first_reg, first_next;
  logic          acked_reg, acked_next;
  logic [7:0]    resp_last_reg, resp_last_next;
  logic          err_reg, err_next;
  logic          clr_reg;
  logic          err_set;
  logic          retry_req;
  logic          consume;
  logic          launch_ok;
  logic          fifo_pop;
  logic [15:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.push),
    .push_data (bus.push_cmd),
    .pop       (fifo_pop),
`ifdef REMOTE_SCHED_FLUSH_EN
    .flush     (bus.flush),
    .keep_head (bus.busy),
`endif
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A flush in IDLE empties the queue, so nothing may be launched then
`ifdef REMOTE_SCHED_FLUSH_EN
  assign launch_ok = !fifo_empty && !bus.flush;
`else
  assign launch_ok = !fifo_empty;
`endif

  // A response byte is taken once; the clear pulse of the previous byte
  // masks resp_rx_rdy until RemoteComm has dropped it.
  assign consume = bus.resp_rx_rdy && !clr_reg &&
                   ((state_reg == IDLE) || (state_reg == WAIT_RESP));

  // err is sticky; a new error beats a simultaneous clear
  assign err_next = err_set | (err_reg & ~bus.err_clr);

  assign bus.full            = fifo_full;
  assign bus.empty           = fifo_empty;
  assign bus.count           = fifo_count;
  assign bus.snd_cmd         = (state_reg == LAUNCH);
  assign bus.cmd             = cmd_reg;
  assign bus.resp_clr_rx_rdy = clr_reg;
  assign bus.busy            = (state_reg == LAUNCH) || (state_reg == WAIT_SNT) ||
                               (state_reg == WAIT_RESP);
  assign bus.done            = (state_reg == RETIRE) && acked_reg;
  assign bus.err             = err_reg;
  assign bus.resp_last       = resp_last_reg;

  // Next-state, timer, retry and pop decisions
  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    retry_next     = retry_reg;
    timer_next     = timer_reg;
    first_next     = 1'b0;
    acked_next     = acked_reg;
    resp_last_next = resp_last_reg;
    err_set        = 1'b0;
    retry_req      = 1'b0;
    fifo_pop       = 1'b0;

    if (consume) resp_last_next = bus.resp_rx_data;

    case (state_reg)
      IDLE: begin
        if (launch_ok) begin
          cmd_next   = fifo_head;
          retry_next = '0;
          acked_next = 1'b0;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        // cmd_snt may still show the previous command's completion
        first_next = 1'b1;
        state_next = WAIT_SNT;
      end
      WAIT_SNT: begin
        if (!first_reg && bus.cmd_snt) begin
          timer_next = '0;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timer_next = timer_reg + 1'b1;
        if (consume) begin
          if (bus.resp_rx_data == RESP_ACK) begin
            acked_next = 1'b1;
            state_next = RETIRE;
          end else begin
            retry_req = 1'b1;
          end
        end else if (timer_reg == TMO_LAST) begin
          retry_req = 1'b1;
        end
        if (retry_req) begin
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 1'b1;
            state_next = LAUNCH;
          end else begin
            err_set    = 1'b1;
            acked_next = 1'b0;
            state_next = RETIRE;
          end
        end
      end
      RETIRE: begin
        fifo_pop   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      retry_reg     <= '0;
      timer_reg     <= '0;
      first_reg     <= 1'b0;
      acked_reg     <= 1'b0;
      resp_last_reg <= '0;
      err_reg       <= 1'b0;
      clr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      retry_reg     <= retry_next;
      timer_reg     <= timer_next;
      first_reg     <= first_next;
      acked_reg     <= acked_next;
      resp_last_reg <= resp_last_next;
      err_reg       <= err_next;
      clr_reg       <= consume;
    end
  end

endmodule
